mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Shares the single-port data RAM between the instruction-fetch port and the MEM-stage data port. It grants one requester at a time and latches that requester's command. It drives the RAM until the RAM acknowledges or a timeout expires, then returns read data with a one-cycle ack. A pipeline stall request is raised whenever a requester is waiting. It sits between IF/MEM and the RAM wrapper, and its stall output feeds the pipeline controller.

## Interface
- `TIMEOUT`, 15: maximum cycles in a BUSY state before abort (1..255).
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low (`rst == 0` resets).
- `if_ce_i`  in  1  fetch request, level, held until `if_ack_o`.
- `if_addr_i`  in  32  fetch word address.
- `if_data_o`  out  32  fetched word, valid with `if_ack_o`.
- `if_ack_o`  out  1  one-cycle fetch completion.
- `d_ce_i`  in  1  data request, level, held until `d_ack_o`.
- `d_we_i`  in  1  1 = store, 0 = load.
- `d_sel_i`  in  4  byte select, bit3 = bits 31:24.
- `d_addr_i`  in  32  data address.
- `d_data_i`  in  32  store data.
- `d_data_o`  out  32  load data, valid with `d_ack_o`.
- `d_ack_o`  out  1  one-cycle data completion.
- `ram_ce_o`  out  1  RAM chip enable.
- `ram_we_o`  out  1  RAM write enable.
- `ram_sel_o`  out  4  RAM byte select.
- `ram_addr_o`  out  32  RAM address.
- `ram_data_o`  out  32  RAM write data.
- `ram_data_i`  in  32  RAM read data, valid with `ram_ack_i`.
- `ram_ack_i`  in  1  RAM completion, one cycle.
- `stall_req_o`  out  1  pipeline stall request.
- `bus_err_o`  out  1  one-cycle pulse on timeout abort.

## Operation
- **States:** IDLE, BUSY_I, BUSY_D, RESP.
- **IDLE, arbitration:**
  - Only one of `d_ce_i` / `if_ce_i` high: grant that one.
  - Both high: grant the port not served last (`last_grant` flag). `last_grant` resets to INST, so data wins the first contention.
- **On grant:** latch the command registers.
  - INST: we=0, sel=4'b1111, data=0, addr=`if_addr_i`.
  - DATA: `d_we_i`, `d_sel_i`, `d_addr_i`, `d_data_i`.
  - Update `last_grant`, clear the timeout counter, go to BUSY_I or BUSY_D.
- **BUSY_x:**
  - `ram_ce_o` = 1 and all RAM outputs driven from the latched registers.
  - Later changes on requester inputs are ignored.
  - Counter increments each cycle.
- **Completion (`ram_ack_i`):** capture `ram_data_i` into the granted port's data register; for a store, capture 0. Go to RESP.
- **Timeout (counter == TIMEOUT-1 without ack):** granted port's data register := 0, pulse `bus_err_o`, go to RESP.
- **RESP:**
  - `ram_ce_o` = 0.
  - The granted port's ack is high for exactly this cycle.
  - Requester drops ce in this cycle.
  - Next state is IDLE. This dead cycle prevents re-granting a request that has already been served.
- **`stall_req_o`** = `(if_ce_i & ~if_ack_o) | (d_ce_i & ~d_ack_o)`, combinational.
- **Data outputs:** `if_data_o` / `d_data_o` hold their last captured value until the next completion for that port.
- **RAM outputs outside BUSY:** `ram_we_o`, `ram_sel_o`, `ram_addr_o`, `ram_data_o` = 0 whenever not in BUSY.
- **`ram_ack_i` outside BUSY:** ignored.

## Timing
- **Reset values:** all outputs 0, state IDLE, counter 0, `last_grant` = INST.
- **Reset mid-transaction:** abandons it immediately; no ack is issued.
- **Registers:** state, command registers, data registers, ack and `bus_err_o` are registered. `stall_req_o` is combinational. RAM outputs decode from state and registers only.
- **Latency:**
  - Request seen in IDLE at cycle 0: RAM driven in cycles 1..N, where N = cycle of `ram_ack_i`.
  - RESP and ack at N+1; IDLE at N+2.
  - Minimum request-to-ack latency is 2 cycles with a same-cycle RAM ack in cycle 1.
- **Timeout:** RESP occurs at cycle TIMEOUT+1 after grant. `bus_err_o` and ack are high together.
- **Ack coincident with timeout cycle:** the ack wins; no error is raised.
- **Counter:** width `$clog2(TIMEOUT+1)`; saturates and never wraps.

## Structure
- **`const.v`:** add state encodings `ARB_IDLE`, `ARB_BUSY_I`, `ARB_BUSY_D`, `ARB_RESP` (2 bits) and grant encodings `GRANT_INST` / `GRANT_DATA`. Reuse `RegBus` for 32-bit fields.
- **No sub-module:** the counter and FSM are inline in `mem_bus_arbiter`.

## Test plan
- **Fetch alone:** `if_ce_i`=1, `if_addr_i`=0x100, RAM acks on cycle 3 with 0xDEADBEEF -> `ram_addr_o`=0x100, `sel`=1111, `we`=0 in cycles 1..3; `if_ack_o` high only in cycle 4 with `if_data_o`=0xDEADBEEF.
- **Store alone:** `d_we_i`=1, `sel`=0100, addr 0x204, data 0x00AB0000 -> RAM sees the exact latched values; `d_ack_o` is pulsed and `d_data_o`=0.
- **Contention, three back-to-back pairs:** both ports request continuously -> grants go DATA, INST, DATA; each transaction is separated by a RESP and an IDLE cycle; `stall_req_o` stays high throughout.
- **Timeout:** TIMEOUT=4, RAM never acks -> RESP after 4 BUSY cycles; `bus_err_o` and `d_ack_o` both pulse; `d_data_o`=0.
- **Async reset:** `rst` low in the middle of BUSY_D -> all outputs 0 immediately and no ack; after release a new fetch is granted normally.
- **Input change during BUSY:** `d_addr_i` changes mid-transaction -> `ram_addr_o` holds the latched address.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the IF/MEM data-RAM arbiter: state and grant encodings,
// the 32-bit register bus type and the latched RAM command.
package mem_bus_arbiter_pkg;

   localparam int REG_W = 32;
   typedef logic [REG_W-1:0] reg_bus_t;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BUSY_I = 2'd1,
      ARB_BUSY_D = 2'd2,
      ARB_RESP   = 2'd3
   } arb_state_e;

   typedef enum logic {
      GRANT_INST = 1'b0,
      GRANT_DATA = 1'b1
   } grant_e;

   typedef struct packed {
      logic       we;
      logic [3:0] sel;
      reg_bus_t   addr;
      reg_bus_t   data;
   } ram_cmd_t;

   localparam logic [3:0] SEL_WORD = 4'b1111;

   // Fetches are always full-word reads.
   function automatic ram_cmd_t inst_cmd(input reg_bus_t addr);
      ram_cmd_t c;
      c.we   = 1'b0;
      c.sel  = SEL_WORD;
      c.addr = addr;
      c.data = '0;
      return c;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch port, data port and RAM-side signals around the arbiter.
// The slave view is the arbiter itself; master is everything around it.
interface mem_bus_arbiter_if;
   import mem_bus_arbiter_pkg::*;

   logic       if_ce_i;
   reg_bus_t   if_addr_i;
   reg_bus_t   if_data_o;
   logic       if_ack_o;

   logic       d_ce_i;
   logic       d_we_i;
   logic [3:0] d_sel_i;
   reg_bus_t   d_addr_i;
   reg_bus_t   d_data_i;
   reg_bus_t   d_data_o;
   logic       d_ack_o;

   logic       ram_ce_o;
   logic       ram_we_o;
   logic [3:0] ram_sel_o;
   reg_bus_t   ram_addr_o;
   reg_bus_t   ram_data_o;
   reg_bus_t   ram_data_i;
   logic       ram_ack_i;

   logic       stall_req_o;
   logic       bus_err_o;

   modport slave (
      input  if_ce_i, if_addr_i, d_ce_i, d_we_i, d_sel_i, d_addr_i, d_data_i,
             ram_data_i, ram_ack_i,
      output if_data_o, if_ack_o, d_data_o, d_ack_o, ram_ce_o, ram_we_o,
             ram_sel_o, ram_addr_o, ram_data_o, stall_req_o, bus_err_o
   );

   modport master (
      output if_ce_i, if_addr_i, d_ce_i, d_we_i, d_sel_i, d_addr_i, d_data_i,
             ram_data_i, ram_ack_i,
      input  if_data_o, if_ack_o, d_data_o, d_ack_o, ram_ce_o, ram_we_o,
             ram_sel_o, ram_addr_o, ram_data_o, stall_req_o, bus_err_o
   );

endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-port data RAM arbiter between instruction fetch and the MEM stage.
// One transaction at a time: IDLE -> BUSY_x -> RESP -> IDLE, with timeout abort.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   mem_bus_arbiter_if.slave bus
);

   localparam int                CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_e       state_q, state_d;
   grant_e           grant_q, grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   ram_cmd_t         cmd_q, cmd_d;
   reg_bus_t         if_data_q, if_data_d;
   reg_bus_t         d_data_q, d_data_d;
   logic             if_ack_q, if_ack_d;
   logic             d_ack_q, d_ack_d;
   logic             bus_err_q, bus_err_d;

   logic busy;
   logic req_any;
   logic pick_data;
   logic timeout_hit;
   logic done;

   assign busy        = (state_q == ARB_BUSY_I) || (state_q == ARB_BUSY_D);
   assign req_any     = bus.if_ce_i | bus.d_ce_i;
   // grant_q doubles as last_grant: data wins a tie unless it was served last.
   assign pick_data   = bus.d_ce_i & (~bus.if_ce_i | (grant_q == GRANT_INST));
   assign timeout_hit = (cnt_q == CNT_LAST);
   assign done        = busy & (bus.ram_ack_i | timeout_hit);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ARB_IDLE;
         grant_q   <= GRANT_INST;
         cnt_q     <= '0;
         cmd_q     <= '0;
         if_data_q <= '0;
         d_data_q  <= '0;
         if_ack_q  <= 1'b0;
         d_ack_q   <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         cnt_q     <= cnt_d;
         cmd_q     <= cmd_d;
         if_data_q <= if_data_d;
         d_data_q  <= d_data_d;
         if_ack_q  <= if_ack_d;
         d_ack_q   <= d_ack_d;
         bus_err_q <= bus_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_data)         state_d = ARB_BUSY_D;
            else if (bus.if_ce_i)  state_d = ARB_BUSY_I;
         end
         ARB_BUSY_I, ARB_BUSY_D: begin
            if (done) state_d = ARB_RESP;
         end
         // The dead cycle lets the served requester drop ce before re-arbitration.
         ARB_RESP: state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      reg_bus_t rdata;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      cmd_d     = cmd_q;
      if_data_d = if_data_q;
      d_data_d  = d_data_q;
      if_ack_d  = 1'b0;
      d_ack_d   = 1'b0;
      bus_err_d = 1'b0;
      rdata     = '0;

      if (state_q == ARB_IDLE && req_any) begin
         cnt_d = '0;
         if (pick_data) begin
            grant_d  = GRANT_DATA;
            cmd_d.we   = bus.d_we_i;
            cmd_d.sel  = bus.d_sel_i;
            cmd_d.addr = bus.d_addr_i;
            cmd_d.data = bus.d_data_i;
         end else begin
            grant_d = GRANT_INST;
            cmd_d   = inst_cmd(bus.if_addr_i);
         end
      end

      if (busy) begin
         if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
         if (done) begin
            // An ack in the last allowed cycle still counts as success.
            if (bus.ram_ack_i && !cmd_q.we) rdata = bus.ram_data_i;
            bus_err_d = ~bus.ram_ack_i;
            if (grant_q == GRANT_INST) begin
               if_data_d = rdata;
               if_ack_d  = 1'b1;
            end else begin
               d_data_d = rdata;
               d_ack_d  = 1'b1;
            end
         end
      end
   end

   always_comb begin
      bus.ram_ce_o   = busy;
      bus.ram_we_o   = 1'b0;
      bus.ram_sel_o  = '0;
      bus.ram_addr_o = '0;
      bus.ram_data_o = '0;
      if (busy) begin
         bus.ram_we_o   = cmd_q.we;
         bus.ram_sel_o  = cmd_q.sel;
         bus.ram_addr_o = cmd_q.addr;
         bus.ram_data_o = cmd_q.data;
      end
   end

   assign bus.if_data_o   = if_data_q;
   assign bus.if_ack_o    = if_ack_q;
   assign bus.d_data_o    = d_data_q;
   assign bus.d_ack_o     = d_ack_q;
   assign bus.bus_err_o   = bus_err_q;
   assign bus.stall_req_o = (bus.if_ce_i & ~if_ack_q) | (bus.d_ce_i & ~d_ack_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: transaction-level reference model compared
// every cycle, plus literal expectations at the interesting points of each scenario.
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   localparam int TO = 4;

   logic clk;
   logic rst;
   mem_bus_arbiter_if bus();

   mem_bus_arbiter #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Reference model: who owns the RAM, how long it has been driven, and
   // whether this is the reply cycle.
   int          m_owner;        // 0 none, 1 fetch, 2 data
   logic        m_driving, m_reply, m_err, m_prefer_data;
   int          m_age;
   logic        m_we;
   logic [3:0]  m_sel;
   logic [31:0] m_addr, m_wdata, m_if_data, m_d_data;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_owner <= 0; m_driving <= 1'b0; m_reply <= 1'b0; m_err <= 1'b0;
         m_prefer_data <= 1'b1; m_age <= 0;
         m_we <= 1'b0; m_sel <= '0; m_addr <= '0; m_wdata <= '0;
         m_if_data <= '0; m_d_data <= '0;
      end else if (m_reply) begin
         m_reply <= 1'b0; m_err <= 1'b0; m_owner <= 0;
      end else if (m_driving) begin
         if (bus.ram_ack_i) begin
            m_driving <= 1'b0; m_reply <= 1'b1;
            if (m_owner == 1) m_if_data <= bus.ram_data_i;
            else              m_d_data  <= m_we ? 32'h0 : bus.ram_data_i;
         end else if (m_age == TO - 1) begin
            m_driving <= 1'b0; m_reply <= 1'b1; m_err <= 1'b1;
            if (m_owner == 1) m_if_data <= 32'h0;
            else              m_d_data  <= 32'h0;
         end else begin
            m_age <= m_age + 1;
         end
      end else if (bus.d_ce_i && (!bus.if_ce_i || m_prefer_data)) begin
         m_owner <= 2; m_driving <= 1'b1; m_age <= 0; m_prefer_data <= 1'b0;
         m_we <= bus.d_we_i; m_sel <= bus.d_sel_i; m_addr <= bus.d_addr_i; m_wdata <= bus.d_data_i;
      end else if (bus.if_ce_i) begin
         m_owner <= 1; m_driving <= 1'b1; m_age <= 0; m_prefer_data <= 1'b1;
         m_we <= 1'b0; m_sel <= 4'hF; m_addr <= bus.if_addr_i; m_wdata <= 32'h0;
      end
   end

   logic e_if_ack, e_d_ack, e_stall;
   assign e_if_ack = m_reply && (m_owner == 1);
   assign e_d_ack  = m_reply && (m_owner == 2);
   assign e_stall  = (bus.if_ce_i && !e_if_ack) || (bus.d_ce_i && !e_d_ack);

   always @(negedge clk) begin
      check("ram_bus", {bus.ram_ce_o, bus.ram_we_o, bus.ram_sel_o, bus.ram_addr_o, bus.ram_data_o},
            m_driving ? {1'b1, m_we, m_sel, m_addr, m_wdata} : 70'd0);
      check("ack_err_stall", {bus.if_ack_o, bus.d_ack_o, bus.bus_err_o, bus.stall_req_o},
            {e_if_ack, e_d_ack, m_reply && m_err, e_stall});
      check("if_data", bus.if_data_o, m_if_data);
      check("d_data", bus.d_data_o, m_d_data);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] grants[$];

   initial begin
      rst = 1'b0;
      bus.if_ce_i = 1'b0; bus.if_addr_i = '0;
      bus.d_ce_i = 1'b0; bus.d_we_i = 1'b0; bus.d_sel_i = '0;
      bus.d_addr_i = '0; bus.d_data_i = '0;
      bus.ram_data_i = '0; bus.ram_ack_i = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs",
            {bus.ram_ce_o, bus.ram_we_o, bus.ram_sel_o, bus.ram_addr_o, bus.ram_data_o,
             bus.if_ack_o, bus.d_ack_o, bus.bus_err_o, bus.stall_req_o}, 128'd0);
      check("reset_data", {bus.if_data_o, bus.d_data_o}, 128'd0);
      #2 rst = 1'b1;
      tick();

      // Contention: both ports keep requesting; each drops ce only in its ack cycle.
      bus.if_addr_i = 32'h300; bus.d_addr_i = 32'h400; bus.d_we_i = 1'b0; bus.d_sel_i = 4'hF;
      for (int c = 0; c < 9; c++) begin
         bus.if_ce_i    = !bus.if_ack_o;
         bus.d_ce_i     = !bus.d_ack_o;
         bus.ram_ack_i  = bus.ram_ce_o;
         bus.ram_data_i = bus.ram_addr_o ^ 32'hA5A5_0000;
         if (bus.ram_ack_i) grants.push_back(bus.ram_addr_o);
         #1 check("contention_stall", bus.stall_req_o, 1'b1);
         if (c == 5) check("contention_if_data", bus.if_data_o, 32'hA5A5_0300);
         if (c == 8) check("contention_d_data", bus.d_data_o, 32'hA5A5_0400);
         if (c < 8) tick();
      end
      bus.if_ce_i = 1'b0; bus.d_ce_i = 1'b0; bus.ram_ack_i = 1'b0;
      check("grant_count", grants.size(), 3);
      if (grants.size() == 3)
         check("grant_order", {grants[0], grants[1], grants[2]}, {32'h400, 32'h300, 32'h400});
      tick();

      // Fetch alone, RAM acks in cycle 3.
      bus.if_ce_i = 1'b1; bus.if_addr_i = 32'h100;
      tick();
      check("fetch_ram_cmd", {bus.ram_ce_o, bus.ram_we_o, bus.ram_sel_o, bus.ram_addr_o},
            {1'b1, 1'b0, 4'hF, 32'h100});
      tick();
      tick();
      bus.ram_ack_i = 1'b1; bus.ram_data_i = 32'hDEADBEEF;
      check("fetch_no_early_ack", bus.if_ack_o, 1'b0);
      tick();
      bus.ram_ack_i = 1'b0;
      check("fetch_ack", {bus.if_ack_o, bus.if_data_o}, {1'b1, 32'hDEADBEEF});
      bus.if_ce_i = 1'b0;
      tick();
      check("fetch_ack_one_cycle", bus.if_ack_o, 1'b0);

      // Store alone; requester inputs change mid-transaction.
      bus.d_ce_i = 1'b1; bus.d_we_i = 1'b1; bus.d_sel_i = 4'b0100;
      bus.d_addr_i = 32'h204; bus.d_data_i = 32'h00AB0000; bus.ram_data_i = 32'h12345678;
      tick();
      check("store_ram_cmd", {bus.ram_we_o, bus.ram_sel_o, bus.ram_data_o}, {1'b1, 4'b0100, 32'h00AB0000});
      bus.d_addr_i = 32'h999; bus.d_data_i = 32'hFFFFFFFF;
      tick();
      check("store_addr_held", {bus.ram_addr_o, bus.ram_data_o}, {32'h204, 32'h00AB0000});
      bus.ram_ack_i = 1'b1;
      tick();
      bus.ram_ack_i = 1'b0;
      check("store_ack", {bus.d_ack_o, bus.d_data_o, bus.bus_err_o}, {1'b1, 32'h0, 1'b0});
      bus.d_ce_i = 1'b0; bus.d_we_i = 1'b0;
      tick();

      // Timeout: load with no RAM ack.
      bus.d_ce_i = 1'b1; bus.d_sel_i = 4'hF; bus.d_addr_i = 32'h500; bus.ram_data_i = 32'hCAFEF00D;
      repeat (4) tick();
      check("timeout_last_busy", {bus.ram_ce_o, bus.bus_err_o, bus.d_ack_o}, {1'b1, 1'b0, 1'b0});
      tick();
      check("timeout_resp", {bus.ram_ce_o, bus.bus_err_o, bus.d_ack_o, bus.d_data_o}, {1'b0, 1'b1, 1'b1, 32'h0});
      bus.d_ce_i = 1'b0;
      tick();
      check("timeout_err_pulse", bus.bus_err_o, 1'b0);

      // RAM ack in the final allowed cycle wins over the timeout.
      bus.if_ce_i = 1'b1; bus.if_addr_i = 32'h600;
      repeat (4) tick();
      bus.ram_ack_i = 1'b1; bus.ram_data_i = 32'h600D600D;
      tick();
      bus.ram_ack_i = 1'b0;
      check("ack_beats_timeout", {bus.if_ack_o, bus.bus_err_o, bus.if_data_o}, {1'b1, 1'b0, 32'h600D600D});
      bus.if_ce_i = 1'b0;
      tick();

      // Async reset in the middle of a data transaction.
      bus.d_ce_i = 1'b1; bus.d_we_i = 1'b1; bus.d_sel_i = 4'b0011;
      bus.d_addr_i = 32'h700; bus.d_data_i = 32'h11;
      tick();
      tick();
      check("pre_reset_busy", {bus.ram_ce_o, bus.ram_addr_o}, {1'b1, 32'h700});
      #2 rst = 1'b0;
      #1;
      check("async_reset_now",
            {bus.ram_ce_o, bus.ram_addr_o, bus.d_ack_o, bus.if_ack_o, bus.if_data_o}, 128'd0);
      bus.d_ce_i = 1'b0; bus.d_we_i = 1'b0;
      tick();
      check("reset_no_ack", {bus.d_ack_o, bus.bus_err_o}, 2'b00);
      #2 rst = 1'b1;
      tick();
      bus.if_ce_i = 1'b1; bus.if_addr_i = 32'h800;
      tick();
      check("post_reset_fetch", {bus.ram_ce_o, bus.ram_addr_o}, {1'b1, 32'h800});
      bus.ram_ack_i = 1'b1; bus.ram_data_i = 32'h0BADF00D;
      tick();
      bus.ram_ack_i = 1'b0;
      check("post_reset_ack", {bus.if_ack_o, bus.if_data_o}, {1'b1, 32'h0BADF00D});
      bus.if_ce_i = 1'b0;
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
